// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU codes, datapath mux selects, FSM states and instruction classes.
package mips_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_NOOP    = 6'b000000;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  // ALU operation codes (funct-style)
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_SLT = 6'b101010;
  localparam logic [5:0] ALU_NOP = 6'b101100;

  // Datapath mux selects
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;
  localparam logic [1:0] RD_RT     = 2'd0;
  localparam logic [1:0] RD_RD     = 2'd1;
  localparam logic [1:0] RD_RA     = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NOOP, C_ADD, C_SUB, C_SLT, C_ADDI, C_XORI, C_LW, C_SW,
    C_BNE, C_J, C_JAL, C_JR, C_SYSCALL
  } class_e;

endpackage

// File: rtl/mips_instr_classify.sv
// Combinational instruction classifier. Unknown encodings report
// illegal_o=1 and a NOOP class, so a "run as NOOP" policy needs no remap.
module mips_instr_classify
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] class_o,
  output logic       illegal_o
);

  // Map opcode/funct to an instruction class.
  always_comb begin
    class_o   = C_NOOP;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_NOOP:    class_o = C_NOOP;
          FN_ADD:     class_o = C_ADD;
          FN_SUB:     class_o = C_SUB;
          FN_SLT:     class_o = C_SLT;
          FN_JR:      class_o = C_JR;
          FN_SYSCALL: class_o = C_SYSCALL;
          default:    illegal_o = 1'b1;
        endcase
      end
      OP_LW:   class_o = C_LW;
      OP_SW:   class_o = C_SW;
      OP_J:    class_o = C_J;
      OP_JAL:  class_o = C_JAL;
      OP_BNE:  class_o = C_BNE;
      OP_XORI: class_o = C_XORI;
      OP_ADDI: class_o = C_ADDI;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait handshake, wait timeout,
// illegal-instruction policy and a retired-instruction counter.
// Strobes are decoded from the registered state; only the handshake
// (mem_ready in FETCH) and branch (zero in EXEC) inputs act in-cycle.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W         = 6,
  parameter int TMO_W           = 4,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               halted,
  output logic               illegal,
  output logic               mem_err,
  output logic [CNT_W-1:0]   retired
);

  // Last waited cycle before the timer would saturate (2**TMO_W-2).
  localparam logic [TMO_W-1:0]   TMO_LAST = ~TMO_W'(1);
  localparam bit                 HALT_ILL = (HALT_ON_ILLEGAL != 0);
  localparam logic [ALUOP_W-1:0] AOP_ADD  = ALUOP_W'(ALU_ADD);
  localparam logic [ALUOP_W-1:0] AOP_SUB  = ALUOP_W'(ALU_SUB);
  localparam logic [ALUOP_W-1:0] AOP_XOR  = ALUOP_W'(ALU_XOR);
  localparam logic [ALUOP_W-1:0] AOP_SLT  = ALUOP_W'(ALU_SLT);
  localparam logic [ALUOP_W-1:0] AOP_NOP  = ALUOP_W'(ALU_NOP);

  state_e           state_q;
  class_e           class_q;
  logic [TMO_W-1:0] tmo_q;
  logic             illegal_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] retired_q;

  logic [3:0] dec_class_raw;
  logic       dec_illegal;
  class_e     dec_class;
  logic       wait_expired;

  mips_instr_classify u_classify (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .class_o   (dec_class_raw),
    .illegal_o (dec_illegal)
  );

  assign dec_class    = class_e'(dec_class_raw);
  assign wait_expired = (tmo_q == TMO_LAST);

  // Sequencing: state, class latched in DECODE, wait timer, sticky flags, retire count.
  // The timer clears on every non-waiting cycle, so it always starts at 0 on FETCH/MEM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      class_q   <= C_NOOP;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      tmo_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (en) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
          end else if (wait_expired) begin
            state_q   <= S_HALT;
            mem_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_DECODE: begin
          class_q <= dec_class;
          if (dec_illegal && HALT_ILL) begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end else begin
            case (dec_class)
              C_NOOP, C_J, C_JAL, C_JR: begin
                state_q   <= S_FETCH;
                retired_q <= retired_q + CNT_W'(1);
              end
              C_SYSCALL: begin
                state_q   <= S_HALT;
                retired_q <= retired_q + CNT_W'(1);
              end
              default: state_q <= S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          case (class_q)
            C_BNE: begin
              state_q   <= S_FETCH;
              retired_q <= retired_q + CNT_W'(1);
            end
            C_LW, C_SW: state_q <= S_MEM;
            default:    state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (class_q == C_SW) begin
              state_q   <= S_FETCH;
              retired_q <= retired_q + CNT_W'(1);
            end else begin
              state_q <= S_WB;
            end
          end else if (wait_expired) begin
            state_q   <= S_HALT;
            mem_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          retired_q <= retired_q + CNT_W'(1);
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath strobes decoded from state; DECODE looks at the live IR, later states at class_q.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    reg_dst   = RD_RT;
    wb_sel    = WB_ALU;
    alu_src   = 1'b0;
    alu_op    = AOP_NOP;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        case (dec_class)
          C_J: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
          C_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PC_JUMP;
            reg_write = 1'b1;
            reg_dst   = RD_RA;
            wb_sel    = WB_PC4;
          end
          C_JR: begin
            pc_write = 1'b1;
            pc_src   = PC_RS;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        case (class_q)
          C_ADD:  alu_op = AOP_ADD;
          C_SUB:  alu_op = AOP_SUB;
          C_SLT:  alu_op = AOP_SLT;
          C_ADDI, C_LW, C_SW: begin
            alu_op  = AOP_ADD;
            alu_src = 1'b1;
          end
          C_XORI: begin
            alu_op  = AOP_XOR;
            alu_src = 1'b1;
          end
          C_BNE: begin
            alu_op   = AOP_SUB;
            pc_write = ~zero;
            pc_src   = PC_BRANCH;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_read  = (class_q == C_LW);
        mem_write = (class_q == C_SW);
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (class_q inside {C_ADD, C_SUB, C_SLT}) ? RD_RD : RD_RT;
        wb_sel    = (class_q == C_LW) ? WB_MEM : WB_ALU;
      end
      default: ;
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign mem_err = mem_err_q;
  assign retired = retired_q;

endmodule
